control_unit: RTL and testbench

- Hardwired Moore/Mealy controller that sequences the Mini-SRC datapath, memory and select/encode logic.
- Replaces the hand-driven T0..T7 control stimulus with an FSM: fetch (T0-T2), then per-opcode execute steps (T3-T7), then back to T0.
- Sits beside `datapath` inside `system`; every control strobe of `system` is driven from here.
- Reads the IR (`out_ir` of datapath) for decode.

---
 rtl/src_pkg.sv | 28 ++
 rtl/control_unit_if.sv | 31 +++
 rtl/control_unit_decode.sv | 30 +++
 rtl/control_unit.sv | 120 ++++++++++++
 tb/tb_control_unit.sv | 138 +++++++++++++
 5 files changed

// File: rtl/src_pkg.sv
// src_pkg: opcode/ALU constants, FSM state and instruction-class types for the Mini-SRC controller.
package src_pkg;
  localparam int ALU_OP_W = 4;
  localparam int OPC_W = 5;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0011;
  // T0..T7 share bit 3 = 0 so the step index is just the low three bits
  typedef enum logic [3:0] {
    ST_T0 = 4'd0, ST_T1 = 4'd1, ST_T2 = 4'd2, ST_T3 = 4'd3,
    ST_T4 = 4'd4, ST_T5 = 4'd5, ST_T6 = 4'd6, ST_T7 = 4'd7,
    ST_RST = 4'd8, ST_IDLE = 4'd9, ST_HALT = 4'd10
  } state_t;
  typedef enum logic [2:0] {CL_LD, CL_LDI, CL_ST, CL_RTYPE, CL_ITYPE, CL_NOP, CL_HALT} instr_class_t;
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: IR/stop inputs and all datapath control strobes between controller and datapath.
interface control_unit_if;
  logic [31:0] in_ir;
  logic in_stop;
  logic out_run, out_halted, out_reg_clear;
  logic [src_pkg::ALU_OP_W-1:0] out_alu_opcode;
  logic out_mdr_select, out_inc_pc;
  logic out_gra, out_grb, out_grc, out_ba_read;
  logic out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read;
  logic out_pc_read, out_mdr_read, out_inport_read, out_c_read, out_mem_read;
  logic out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write, out_mdr_write;
  logic out_ir_write, out_y_write, out_mar_write, out_mem_write, out_outport_write;
  modport master (
    input in_ir, in_stop,
    output out_run, out_halted, out_reg_clear, out_alu_opcode, out_mdr_select, out_inc_pc,
    output out_gra, out_grb, out_grc, out_ba_read,
    output out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read,
    output out_pc_read, out_mdr_read, out_inport_read, out_c_read, out_mem_read,
    output out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write, out_mdr_write,
    output out_ir_write, out_y_write, out_mar_write, out_mem_write, out_outport_write
  );
  modport slave (
    output in_ir, in_stop,
    input out_run, out_halted, out_reg_clear, out_alu_opcode, out_mdr_select, out_inc_pc,
    input out_gra, out_grb, out_grc, out_ba_read,
    input out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read,
    input out_pc_read, out_mdr_read, out_inport_read, out_c_read, out_mem_read,
    input out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write, out_mdr_write,
    input out_ir_write, out_y_write, out_mar_write, out_mem_write, out_outport_write
  );
endinterface

// File: rtl/control_unit_decode.sv
// opcode_decode: maps an opcode to its instruction class, ALU operation and final execute step.
module opcode_decode
  import src_pkg::*;
(
  input  logic [OPC_W-1:0]    opcode,
  output instr_class_t        cls,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [2:0]          last_step
);
  always_comb begin
    cls = CL_NOP;
    alu_op = ALU_ADD;
    case (opcode)
      OP_LD:   cls = CL_LD;
      OP_LDI:  cls = CL_LDI;
      OP_ST:   cls = CL_ST;
      OP_ADD:  cls = CL_RTYPE;
      OP_SUB:  begin cls = CL_RTYPE; alu_op = ALU_SUB; end
      OP_AND:  begin cls = CL_RTYPE; alu_op = ALU_AND; end
      OP_OR:   begin cls = CL_RTYPE; alu_op = ALU_OR; end
      OP_ADDI: cls = CL_ITYPE;
      OP_ANDI: begin cls = CL_ITYPE; alu_op = ALU_AND; end
      OP_ORI:  begin cls = CL_ITYPE; alu_op = ALU_OR; end
      OP_HALT: cls = CL_HALT;
      default: cls = CL_NOP;
    endcase
    last_step = (cls == CL_LD || cls == CL_ST) ? 3'd7
              : (cls == CL_LDI || cls == CL_RTYPE || cls == CL_ITYPE) ? 3'd5 : 3'd3;
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/execute sequencer driving every Mini-SRC control strobe.
module control_unit
  import src_pkg::*;
(
  input logic clk,
  input logic in_reset,
  control_unit_if.master bus
);
  state_t state_q, state_d;
  instr_class_t cls;
  logic [ALU_OP_W-1:0] alu_op;
  logic [2:0] last_step, step;
  logic in_t, at_last, mem_cls, is_ld, is_st, is_r;
  opcode_decode u_dec (.opcode(bus.in_ir[31:27]), .cls(cls), .alu_op(alu_op), .last_step(last_step));
  assign in_t = !state_q[3];
  assign step = state_q[2:0];
  assign at_last = in_t && step == last_step;
  assign is_ld = cls == CL_LD;
  assign is_st = cls == CL_ST;
  assign is_r = cls == CL_RTYPE;
  assign mem_cls = is_ld || is_st || cls == CL_LDI;
  always_ff @(posedge clk) state_q <= in_reset ? ST_RST : state_d;
  always_comb begin
    state_d = ST_RST;
    case (state_q)
      ST_RST, ST_IDLE: state_d = bus.in_stop ? ST_IDLE : ST_T0;
      ST_HALT: state_d = ST_HALT;
      ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7:
        state_d = !at_last ? state_t'(state_q + 4'd1)
                : cls == CL_HALT ? ST_HALT
                : bus.in_stop ? ST_IDLE : ST_T0;
      default: state_d = ST_RST;
    endcase
  end
  always_comb begin
    bus.out_run = in_t;
    bus.out_halted = state_q == ST_HALT;
    bus.out_reg_clear = state_q == ST_RST;
    bus.out_alu_opcode = ALU_ADD;
    bus.out_mdr_select = 1'b0;
    bus.out_inc_pc = 1'b0;
    bus.out_gra = 1'b0;
    bus.out_grb = 1'b0;
    bus.out_grc = 1'b0;
    bus.out_ba_read = 1'b0;
    bus.out_regfile_read = 1'b0;
    bus.out_hi_read = 1'b0;
    bus.out_lo_read = 1'b0;
    bus.out_z_hi_read = 1'b0;
    bus.out_z_lo_read = 1'b0;
    bus.out_pc_read = 1'b0;
    bus.out_mdr_read = 1'b0;
    bus.out_inport_read = 1'b0;
    bus.out_c_read = 1'b0;
    bus.out_mem_read = 1'b0;
    bus.out_regfile_write = 1'b0;
    bus.out_hi_write = 1'b0;
    bus.out_lo_write = 1'b0;
    bus.out_z_write = 1'b0;
    bus.out_pc_write = 1'b0;
    bus.out_mdr_write = 1'b0;
    bus.out_ir_write = 1'b0;
    bus.out_y_write = 1'b0;
    bus.out_mar_write = 1'b0;
    bus.out_mem_write = 1'b0;
    bus.out_outport_write = 1'b0;
    if (in_t) begin
      case (step)
        3'd0: begin
          bus.out_pc_read = 1'b1;
          bus.out_mar_write = 1'b1;
          bus.out_inc_pc = 1'b1;
          bus.out_pc_write = 1'b1;
          bus.out_mem_read = 1'b1;
        end
        3'd1: begin
          bus.out_mdr_select = 1'b1;
          bus.out_mdr_write = 1'b1;
        end
        3'd2: begin
          bus.out_mdr_read = 1'b1;
          bus.out_ir_write = 1'b1;
        end
        // nop/halt/undefined end here with no strobes
        3'd3: if (cls != CL_NOP && cls != CL_HALT) begin
          bus.out_grb = 1'b1;
          bus.out_y_write = 1'b1;
          bus.out_ba_read = mem_cls;
          bus.out_regfile_read = !mem_cls;
        end
        3'd4: begin
          bus.out_z_write = 1'b1;
          bus.out_alu_opcode = alu_op;
          bus.out_grc = is_r;
          bus.out_regfile_read = is_r;
          bus.out_c_read = !is_r;
        end
        3'd5: begin
          bus.out_z_lo_read = 1'b1;
          bus.out_mar_write = is_ld || is_st;
          bus.out_mem_read = is_ld;
          bus.out_gra = !(is_ld || is_st);
          bus.out_regfile_write = !(is_ld || is_st);
        end
        3'd6: begin
          bus.out_mdr_write = 1'b1;
          bus.out_mdr_select = is_ld;
          bus.out_gra = is_st;
          bus.out_regfile_read = is_st;
        end
        default: begin
          bus.out_mdr_read = is_ld;
          bus.out_gra = is_ld;
          bus.out_regfile_write = is_ld;
          bus.out_mem_write = is_st;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: random instruction stream checked against per-opcode microprogram lists.
module tb_control_unit;
  import src_pkg::*;
  logic clk = 1'b0;
  logic in_reset;
  always #5 clk = ~clk;
  control_unit_if bus();
  control_unit dut (.clk(clk), .in_reset(in_reset), .bus(bus));
  localparam logic [33:0] K_OUTP_W = 34'd1 << 0,  K_MEM_W = 34'd1 << 1,  K_MAR_W = 34'd1 << 2;
  localparam logic [33:0] K_Y_W    = 34'd1 << 3,  K_IR_W  = 34'd1 << 4,  K_MDR_W = 34'd1 << 5;
  localparam logic [33:0] K_PC_W   = 34'd1 << 6,  K_Z_W   = 34'd1 << 7,  K_LO_W  = 34'd1 << 8;
  localparam logic [33:0] K_HI_W   = 34'd1 << 9,  K_RF_W  = 34'd1 << 10, K_MEM_R = 34'd1 << 11;
  localparam logic [33:0] K_C_R    = 34'd1 << 12, K_IN_R  = 34'd1 << 13, K_MDR_R = 34'd1 << 14;
  localparam logic [33:0] K_PC_R   = 34'd1 << 15, K_ZLO_R = 34'd1 << 16, K_ZHI_R = 34'd1 << 17;
  localparam logic [33:0] K_LO_R   = 34'd1 << 18, K_HI_R  = 34'd1 << 19, K_RF_R  = 34'd1 << 20;
  localparam logic [33:0] K_BA_R   = 34'd1 << 21, K_GRC   = 34'd1 << 22, K_GRB   = 34'd1 << 23;
  localparam logic [33:0] K_GRA    = 34'd1 << 24, K_INC   = 34'd1 << 25, K_MSEL  = 34'd1 << 26;
  localparam logic [33:0] K_CLR    = 34'd1 << 31, K_HALTED = 34'd1 << 32, K_RUN  = 34'd1 << 33;
  localparam logic [33:0] BUS_MASK = K_C_R | K_IN_R | K_MDR_R | K_PC_R | K_ZLO_R | K_ZHI_R | K_LO_R | K_HI_R | K_RF_R;
  logic [33:0] obs;
  assign obs = {bus.out_run, bus.out_halted, bus.out_reg_clear, bus.out_alu_opcode, bus.out_mdr_select,
                bus.out_inc_pc, bus.out_gra, bus.out_grb, bus.out_grc, bus.out_ba_read,
                bus.out_regfile_read, bus.out_hi_read, bus.out_lo_read, bus.out_z_hi_read, bus.out_z_lo_read,
                bus.out_pc_read, bus.out_mdr_read, bus.out_inport_read, bus.out_c_read, bus.out_mem_read,
                bus.out_regfile_write, bus.out_hi_write, bus.out_lo_write, bus.out_z_write, bus.out_pc_write,
                bus.out_mdr_write, bus.out_ir_write, bus.out_y_write, bus.out_mar_write, bus.out_mem_write,
                bus.out_outport_write};
  int n_cmp = 0;
  int n_bad = 0;
  logic [33:0] exp_q[$];
  logic [4:0] pool[12] = '{OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
                           OP_ADDI, OP_ANDI, OP_ORI, OP_NOP, 5'b11111};
  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [33:0] alu_of(input logic [4:0] op);
    return op == OP_SUB ? 34'h1 << 27
         : (op == OP_AND || op == OP_ANDI) ? 34'h2 << 27
         : (op == OP_OR || op == OP_ORI) ? 34'h3 << 27 : 34'h0;
  endfunction
  // The expected cycle-by-cycle microprogram for one instruction, T0 through its last step
  function automatic void build(input logic [4:0] op);
    exp_q = {};
    exp_q.push_back(K_RUN | K_PC_R | K_MAR_W | K_INC | K_PC_W | K_MEM_R);
    exp_q.push_back(K_RUN | K_MSEL | K_MDR_W);
    exp_q.push_back(K_RUN | K_MDR_R | K_IR_W);
    if (op == OP_LD || op == OP_LDI || op == OP_ST) begin
      exp_q.push_back(K_RUN | K_GRB | K_BA_R | K_Y_W);
      exp_q.push_back(K_RUN | K_C_R | K_Z_W);
      if (op == OP_LD) begin
        exp_q.push_back(K_RUN | K_ZLO_R | K_MAR_W | K_MEM_R);
        exp_q.push_back(K_RUN | K_MSEL | K_MDR_W);
        exp_q.push_back(K_RUN | K_MDR_R | K_GRA | K_RF_W);
      end else if (op == OP_ST) begin
        exp_q.push_back(K_RUN | K_ZLO_R | K_MAR_W);
        exp_q.push_back(K_RUN | K_GRA | K_RF_R | K_MDR_W);
        exp_q.push_back(K_RUN | K_MEM_W);
      end else exp_q.push_back(K_RUN | K_ZLO_R | K_GRA | K_RF_W);
    end else if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI}) begin
      exp_q.push_back(K_RUN | K_GRB | K_RF_R | K_Y_W);
      exp_q.push_back(K_RUN | K_Z_W | alu_of(op) | (op inside {OP_ADDI, OP_ANDI, OP_ORI} ? K_C_R : K_GRC | K_RF_R));
      exp_q.push_back(K_RUN | K_ZLO_R | K_GRA | K_RF_W);
    end else exp_q.push_back(K_RUN);
  endfunction
  task automatic run_instr(input logic [31:0] ir, input logic stop);
    bus.in_ir = ir;
    build(ir[31:27]);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("op%02h_t%0d", ir[31:27], i), obs, exp_q[i]);
      check("one_bus_driver", {33'd0, $countones(obs & BUS_MASK) <= 1}, 34'd1);
      if (i == exp_q.size() - 1) bus.in_stop = stop;
      @(negedge clk);
    end
  endtask
  task automatic idle_then_resume(input int k);
    for (int j = 0; j < k; j++) begin
      check("idle", obs, 34'd0);
      if (j == k - 1) bus.in_stop = 1'b0;
      @(negedge clk);
    end
  endtask
  initial begin
    logic [4:0] opc;
    logic stop;
    in_reset = 1'b1;
    bus.in_stop = 1'b0;
    bus.in_ir = 32'h0;
    @(negedge clk);
    check("reset_c1", obs, K_CLR);
    @(negedge clk);
    check("reset_c2", obs, K_CLR);
    in_reset = 1'b0;
    @(negedge clk);
    run_instr(32'h00800055, 1'b0);
    run_instr(32'h10800055, 1'b0);
    run_instr(32'h21180000, 1'b0);
    run_instr({OP_ADDI, 27'h0100005}, 1'b1);
    idle_then_resume(2);
    run_instr({5'b11111, 27'h1234567}, 1'b0);
    for (int n = 0; n < 60; n++) begin
      opc = ($urandom_range(0, 3) == 0) ? 5'($urandom) : pool[$urandom_range(0, 11)];
      if (opc == OP_HALT) opc = OP_NOP;
      stop = $urandom_range(0, 4) == 0;
      run_instr({opc, 27'($urandom)}, stop);
      if (stop) idle_then_resume(int'($urandom_range(1, 3)));
    end
    bus.in_ir = 32'h00800055;
    build(OP_LD);
    for (int i = 0; i <= 4; i++) begin
      check($sformatf("abort_ld_t%0d", i), obs, exp_q[i]);
      if (i == 4) in_reset = 1'b1;
      @(negedge clk);
    end
    check("abort_to_rst", obs, K_CLR);
    in_reset = 1'b0;
    @(negedge clk);
    run_instr(32'hD8000000, 1'b0);
    for (int c = 0; c < 20; c++) begin
      check($sformatf("halt_c%0d", c), obs, K_HALTED);
      bus.in_stop = 1'($urandom);
      bus.in_ir = $urandom;
      @(negedge clk);
    end
    bus.in_stop = 1'b0;
    in_reset = 1'b1;
    @(negedge clk);
    check("halt_exit_rst", obs, K_CLR);
    in_reset = 1'b0;
    @(negedge clk);
    run_instr(32'h00800055, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
